// File: rtl/vga_write_arbiter.sv
// Round-robin arbiter sharing the VGA adapter write port between three pixel producers.
// Writes are gated by a periodic frame window; the output register adds one cycle of latency.
module vga_write_arbiter #(
  parameter int FRAME_PERIOD = 1700000,
  parameter int WINDOW       = 1000,
  parameter int CW           = 21
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  req_valid,
  input  logic [23:0] req_x,
  input  logic [20:0] req_y,
  input  logic [53:0] req_colour,
  output logic [2:0]  req_ready,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [17:0] vga_colour,
  output logic        vga_write,
  output logic        window_open,
  output logic        frame_start
);

  typedef enum logic [1:0] {
    REQ0 = 2'd0,
    REQ1 = 2'd1,
    REQ2 = 2'd2
  } req_id_t;

  localparam logic [CW-1:0] RELOAD  = CW'(FRAME_PERIOD - 1);
  localparam logic [CW-1:0] WIN_LIM = CW'(WINDOW);

  logic [CW-1:0] cnt;
  req_id_t       last;
  req_id_t       pick;
  logic [2:0]    grant;
  logic [1:0]    idx;
  logic          xfer;
  logic [7:0]    sel_x;
  logic [6:0]    sel_y;
  logic [17:0]   sel_colour;

  assign window_open = (cnt < WIN_LIM);
  assign frame_start = (cnt == '0);

  // Search starts one past the last grant and wraps; first valid requester wins.
  always_comb begin
    grant = '0;
    pick  = last;
    idx   = '0;
    for (int unsigned i = 1; i <= 3; i++) begin
      idx = 2'((32'(last) + i) % 3);
      if (!reset && window_open && (grant == '0) && req_valid[idx]) begin
        grant[idx] = 1'b1;
        pick       = req_id_t'(idx);
      end
    end
  end

  assign req_ready = grant;
  assign xfer      = |grant;

  always_comb begin
    sel_x      = '0;
    sel_y      = '0;
    sel_colour = '0;
    case (pick)
      REQ0: begin
        sel_x      = req_x[7:0];
        sel_y      = req_y[6:0];
        sel_colour = req_colour[17:0];
      end
      REQ1: begin
        sel_x      = req_x[15:8];
        sel_y      = req_y[13:7];
        sel_colour = req_colour[35:18];
      end
      REQ2: begin
        sel_x      = req_x[23:16];
        sel_y      = req_y[20:14];
        sel_colour = req_colour[53:36];
      end
      default: begin
        sel_x      = '0;
        sel_y      = '0;
        sel_colour = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt        <= RELOAD;
      last       <= REQ2;
      vga_write  <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
    end else begin
      cnt <= (cnt == '0) ? RELOAD : cnt - CW'(1);
      if (xfer) begin
        last <= pick;
      end
      // Idle cycles drive a zeroed bus so the adapter never sees stale pixels.
      vga_write  <= xfer;
      vga_x      <= xfer ? sel_x : '0;
      vga_y      <= xfer ? sel_y : '0;
      vga_colour <= xfer ? sel_colour : '0;
    end
  end

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Bench for vga_write_arbiter with a small frame (period 8, window 3): directed scenarios
// followed by random traffic, all compared against a cycle-level reference model.
module tb_vga_write_arbiter;

  localparam int FP  = 8;
  localparam int WIN = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  req_valid;
  logic [23:0] req_x;
  logic [20:0] req_y;
  logic [53:0] req_colour;
  logic [2:0]  req_ready;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [17:0] vga_colour;
  logic        vga_write;
  logic        window_open;
  logic        frame_start;

  vga_write_arbiter #(.FRAME_PERIOD(FP), .WINDOW(WIN), .CW(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_colour (req_colour),
    .req_ready  (req_ready),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_write  (vga_write),
    .window_open(window_open),
    .frame_start(frame_start)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: cycles since reset release, last grant, pending output word.
  int          mcyc = 0;
  int          mlast = 2;
  logic        ew = 1'b0;
  logic [7:0]  ex = '0;
  logic [6:0]  ey = '0;
  logic [17:0] ec = '0;
  bit          checks_on = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, mcyc, obs, exp);
    end
  endtask

  task automatic set_data(input int i, input logic [7:0] x, input logic [6:0] y,
                          input logic [17:0] c);
    req_x[8*i +: 8]       = x;
    req_y[7*i +: 7]       = y;
    req_colour[18*i +: 18] = c;
  endtask

  // One clock cycle: check everything visible now, advance the model, cross the edge.
  task automatic step();
    int   phase;
    bit   win;
    bit   fs;
    int   g;
    int   j;
    logic [2:0] er;
    @(negedge clock);
    phase = mcyc % FP;
    win   = (phase >= FP - WIN);
    fs    = (phase == FP - 1);
    g     = -1;
    if (!reset && win) begin
      for (int k = 1; k <= 3; k++) begin
        j = (mlast + k) % 3;
        if (g < 0 && req_valid[j]) g = j;
      end
    end
    er = (g >= 0) ? 3'(1 << g) : 3'b000;
    if (checks_on) begin
      chk("window_open", 32'(window_open), 32'(win));
      chk("frame_start", 32'(frame_start), 32'(fs));
      chk("req_ready",   32'(req_ready),   32'(er));
      chk("vga_write",   32'(vga_write),   32'(ew));
      chk("vga_x",       32'(vga_x),       32'(ex));
      chk("vga_y",       32'(vga_y),       32'(ey));
      chk("vga_colour",  32'(vga_colour),  32'(ec));
    end
    if (reset) begin
      mcyc  = 0;
      mlast = 2;
      ew = 1'b0; ex = '0; ey = '0; ec = '0;
    end else begin
      if (g >= 0) begin
        mlast = g;
        ew = 1'b1;
        ex = req_x[8*g +: 8];
        ey = req_y[7*g +: 7];
        ec = req_colour[18*g +: 18];
      end else begin
        ew = 1'b0; ex = '0; ey = '0; ec = '0;
      end
      mcyc++;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = '0;
    req_x      = '0;
    req_y      = '0;
    req_colour = '0;
    step();
    step();
    checks_on = 1'b1;
    reset     = 1'b0;

    // T1: idle frame tick over two periods
    repeat (16) step();

    // T2: lone requester 0
    do_reset();
    set_data(0, 8'h12, 7'h05, 18'h3FFFF);
    req_valid = 3'b001;
    repeat (10) step();

    // T3: all three compete, then requester 1 drops out
    do_reset();
    set_data(0, 8'hA0, 7'h10, 18'h00111);
    set_data(1, 8'hB1, 7'h21, 18'h02222);
    set_data(2, 8'hC2, 7'h32, 18'h13333);
    req_valid = 3'b111;
    repeat (16) step();
    req_valid = 3'b101;
    repeat (8) step();

    // T4: requester 2 waits outside the window; data changes before its grant
    do_reset();
    req_valid = 3'b100;
    set_data(2, 8'h11, 7'h11, 18'h11111);
    repeat (3) step();
    set_data(2, 8'h5A, 7'h6B, 18'h2ABCD);
    repeat (6) step();

    // T5: withdrawn request leaves arbitration untouched
    do_reset();
    req_valid = 3'b000;
    repeat (2) step();
    req_valid = 3'b010;
    step();
    req_valid = 3'b000;
    repeat (2) step();
    req_valid = 3'b011;
    set_data(0, 8'h01, 7'h02, 18'h00003);
    repeat (4) step();

    // T6: reset while a write is in flight
    do_reset();
    set_data(0, 8'h77, 7'h44, 18'h15555);
    set_data(2, 8'h99, 7'h33, 18'h0AAAA);
    req_valid = 3'b101;
    repeat (6) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (10) step();

    // Random traffic with occasional resets
    repeat (400) begin
      reset     = ($urandom % 60) == 0;
      req_valid = 3'($urandom);
      for (int i = 0; i < 3; i++)
        set_data(i, 8'($urandom), 7'($urandom), 18'($urandom));
      step();
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
